// File: rtl/vga_pkg.sv
// Shared types and the default-palette generator for the VGA palette controller.
package vga_pkg;

  typedef logic [23:0] rgb_t;

  localparam int unsigned PAL_ENTRIES = 256;

  typedef enum logic {StInit, StRun} state_e;

  // RGB332 index expanded to RGB888 by bit replication.
  function automatic rgb_t pal_default(input logic [7:0] idx);
    return {idx[7:5], idx[7:5], idx[7:6],
            idx[4:2], idx[4:2], idx[4:3],
            idx[1:0], idx[1:0], idx[1:0], idx[1:0]};
  endfunction

endpackage

// File: rtl/vga_palette_ctrl_if.sv
// Scan-out and CPU palette-write signals of the palette controller.
interface vga_palette_ctrl_if;
  import vga_pkg::*;

  logic [7:0] in_code;
  logic       in_valid;
  rgb_t       out_color;
  logic       out_valid;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_index;
  rgb_t       wr_color;
  logic       init_busy;

  modport master (
    output in_code, in_valid, wr_valid, wr_index, wr_color,
    input  out_color, out_valid, wr_ready, init_busy
  );

  modport slave (
    input  in_code, in_valid, wr_valid, wr_index, wr_color,
    output out_color, out_valid, wr_ready, init_busy
  );

endinterface

// File: rtl/palette_wr_fifo.sv
// Synchronous FIFO buffering CPU palette writes; head is presented on rdata.
module palette_wr_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign rdata = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vga_palette_ctrl.sv
// 256-entry RGB888 palette: default load after reset, 1-cycle scan-out lookup,
// buffered CPU writes committed only on blanking cycles.
module vga_palette_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  vga_palette_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [7:0] init_cnt_q, init_cnt_d;

  rgb_t       ram [PAL_ENTRIES];
  logic       ram_we;
  logic [7:0] ram_waddr;
  rgb_t       ram_wdata;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic        wr_ready;

  rgb_t out_color_q;
  logic out_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StInit;
      init_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 8'd1;
        if (init_cnt_q == 8'hFF) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Registered-only terms keep wr_ready independent of wr_valid.
  assign wr_ready  = (state_q == StRun) && !fifo_full;
  assign fifo_push = bus.wr_valid && wr_ready;
  assign fifo_pop  = (state_q == StRun) && !bus.in_valid && !fifo_empty;

  palette_wr_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(32)
  ) u_wr_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (fifo_push),
    .wdata ({bus.wr_index, bus.wr_color}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fifo_head[31:24];
    ram_wdata = fifo_head[23:0];
    if (state_q == StInit) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt_q;
      ram_wdata = pal_default(init_cnt_q);
    end else if (fifo_pop) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // CPU writes never coincide with a pixel read, so no bypass is needed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_color_q <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid && (state_q == StRun)) begin
        out_color_q <= ram[bus.in_code];
      end else begin
        out_color_q <= '0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_color = out_color_q;
  assign bus.wr_ready  = wr_ready;
  assign bus.init_busy = (state_q == StInit);

endmodule
